tb_uart_rx_fifo: RTL and testbench
==================================

# tb_uart_rx_fifo

Synthesizable UART receive monitor that sits directly downstream of the chip's UART TX pin (`mprj_io[6]`) in the full-chip bench. It oversamples the serial line with the bench clock, deframes 8N1 characters, and buffers them in a small FIFO with a valid/ready output. Firmware console output and pass/fail messages can then be consumed by a checker, or by the Verilator/cocotb side, without timing-sensitive HDL delays.

## Interface
Parameters:
- `CLKS_PER_BIT`, 347: bench clocks per UART bit (40 MHz / 115200). Legal values ≥ 4.
- `DEPTH`, 16: FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clock`  in  1  bench clock; all logic on the rising edge.
- `resetb`  in  1  asynchronous, active-low reset.
- `ser_rx`  in  1  serial line, idle high. Asynchronous to `clock`.
- `out_data`  out  8  byte at the FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head byte when `out_valid && out_ready`.
- `eol`  out  1  one-cycle pulse when byte 0x0A is pushed.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overflow`  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- `ser_rx` passes through a 2-flop synchronizer, which resets to 1. Call the output `rx_s` and its previous value `rx_q`.
- The FSM has four states:
  - **IDLE**: bit counter and clock counter are 0. On `rx_q==1 && rx_s==0`, go to START.
  - **START**: wait `CLKS_PER_BIT/2` clocks (integer division), then sample `rx_s`.
    - If 0, go to DATA.
    - If 1, treat it as a glitch: return to IDLE with no flags.
  - **DATA**: every `CLKS_PER_BIT` clocks, sample `rx_s` into the shift register, LSB first. After the 8th sample, go to STOP.
  - **STOP**: after `CLKS_PER_BIT` clocks, sample `rx_s`.
    - If 1, push the byte.
    - If 0, pulse `frame_err` and discard the byte.
    - In both cases return to IDLE.
- A line held low (break) after a framing error does not start a new frame. A new frame starts only on the next falling edge.
- Push into the FIFO:
  - FIFO not full: write the byte and raise `eol` in the same cycle if the byte is 0x0A.
  - FIFO full and no pop this cycle: drop the byte and pulse `overflow`; `eol` is not raised.
  - FIFO full and a pop in the same cycle: the push is accepted.
- Pop: `out_valid && out_ready` advances the read pointer. `out_data` is stable while `out_valid && !out_ready`.
- Simultaneous push and pop with the FIFO non-empty: `level` is unchanged.
- Pointers are `$clog2(DEPTH)+1` bits wide and wrap naturally.
  - Full is `wptr-rptr==DEPTH`.
  - Empty is `wptr==rptr`.
- Reset during a frame returns the FSM to IDLE and empties the FIFO. The partial byte is lost and no flag is raised.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `eol`=0, `frame_err`=0, `overflow`=0, `level`=0, FSM=IDLE.
- Detect latency: 2 clocks of synchronizer plus 1 clock of edge detect from the `ser_rx` fall to START entry.
- The stop-bit sample lands at about 9.5 bit-times after the start edge. The byte is written on that clock edge, and `out_valid`/`level` reflect it on the following cycle.
- `eol`, `frame_err` and `overflow` are registered, asserted for exactly 1 cycle, coincident with the push-decision cycle.
- Back-to-back frames are supported. A start edge immediately after the stop sample (same or next clock) is captured, because IDLE re-arms in 1 cycle.
- Throughput: the FIFO accepts one push and one pop per cycle.

## Structure
- Package `tb_uart_pkg` holds:
  - the FSM state enum: `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`;
  - the constant `UART_LF = 8'h0A`.
- Sub-module `tb_uart_sync_fifo` (parameters `WIDTH`, `DEPTH`) is the register-array FIFO with `level`, full and empty. The top module contains the synchronizer, FSM and counters.

## Test plan
All scenarios use `CLKS_PER_BIT=8`, `DEPTH=4`.
- **Single byte:** send 0x55 at 8 clocks/bit with `out_ready=1`. `out_valid` pulses with `out_data`=0x55, `level` peaks at 1, and no flags are raised.
- **Back-to-back string:** send "OK\n" (0x4F, 0x4B, 0x0A) with no idle gap and `out_ready=0`. `level`=3, `eol` pulses once on the third push, and draining yields 0x4F, 0x4B, 0x0A in order.
- **Glitch rejection:** drive `ser_rx` low for 3 clocks, then high. The FSM returns to IDLE with no push and no `frame_err`.
- **Framing error:** send 0xA5 with the stop bit low, then hold the line low for 20 clocks, then send 0x31. There is one `frame_err` pulse, no push for 0xA5, and only 0x31 lands in the FIFO.
- **Overflow:** send 5 bytes (0x01–0x05) with `out_ready=0`. `level`=4, the 5th byte produces an `overflow` pulse, and draining yields 0x01–0x04.
- **Reset mid-frame:** assert `resetb`=0 during DATA bit 4, release it, then send 0x7E. After reset the FIFO is empty, and only 0x7E is received.

Source files
------------

// File: rtl/tb_uart_rx_fifo_pkg.sv
// Shared types and constants for the bench-side UART receive monitor.
package tb_uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] UART_LF = 8'h0A;

endpackage

// File: rtl/tb_uart_rx_fifo_sync_fifo.sv
// Register-array FIFO; a push into a full FIFO is accepted only alongside a pop.
module tb_uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     push_ok
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             full, do_pop;

    assign level   = wptr - rptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wptr == rptr);
    assign do_pop  = pop && !empty;
    assign push_ok = push && (!full || do_pop);
    assign rd_data = mem[rptr[AW-1:0]];

    // Storage resets too so the head byte reads as zero out of reset.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/tb_uart_rx_fifo.sv
// 8N1 UART receiver: synchronizer, deframing FSM and an output FIFO with status pulses.
module tb_uart_rx_fifo
    import tb_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347,
    parameter int DEPTH        = 16
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic                   ser_rx,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   eol,
    output logic                   frame_err,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic            sync1, rx_s, rx_q;
    rx_state_e       state, state_n;
    logic [CW-1:0]   clk_cnt, clk_n;
    logic [2:0]      bit_cnt, bit_n;
    logic [7:0]      shreg, sh_n;
    logic            push, ferr_n, push_ok, empty;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            sync1 <= ser_rx;
            rx_s  <= sync1;
            rx_q  <= rx_s;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state   <= RX_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_n;
            bit_cnt <= bit_n;
            shreg   <= sh_n;
        end
    end

    always_comb begin
        state_n = state;
        clk_n   = clk_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            RX_IDLE: begin
                clk_n = '0;
                bit_n = '0;
                // Edge-triggered so a held-low break never restarts a frame.
                if (rx_q && !rx_s) state_n = RX_START;
            end
            RX_START: begin
                if (clk_cnt == CW'(HALF-1)) begin
                    clk_n   = '0;
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    clk_n = clk_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt == CW'(CLKS_PER_BIT-1)) begin
                    clk_n = '0;
                    sh_n  = {rx_s, shreg[7:1]};
                    bit_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = RX_STOP;
                end else begin
                    clk_n = clk_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (clk_cnt == CW'(CLKS_PER_BIT-1)) begin
                    clk_n   = '0;
                    state_n = RX_IDLE;
                    push    = rx_s;
                    ferr_n  = !rx_s;
                end else begin
                    clk_n = clk_cnt + 1'b1;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    tb_uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .resetb    (resetb),
        .push      (push),
        .push_data (shreg),
        .pop       (out_ready),
        .rd_data   (out_data),
        .level     (level),
        .empty     (empty),
        .push_ok   (push_ok)
    );

    assign out_valid = !empty;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            eol       <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            eol       <= push_ok && (shreg == UART_LF);
            frame_err <= ferr_n;
            overflow  <= push && !push_ok;
        end
    end

endmodule

// File: tb/tb_tb_uart_rx_fifo.sv
// Bench for tb_uart_rx_fifo: serial frames in, FIFO contents and status pulses checked against a queue model.
module tb_tb_uart_rx_fifo;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       ser_rx = 1'b1;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, eol, frame_err, overflow;
    logic [2:0] level;

    int pass_cnt = 0, chk_cnt = 0;
    int eol_n = 0, ferr_n = 0, ovf_n = 0, max_lvl = 0, stab_err = 0;
    logic       hold = 1'b0;
    logic [7:0] hold_data = '0;
    logic [7:0] rcv[$];
    logic [7:0] expq[$];
    int exp_ovf = 0;

    tb_uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .resetb    (resetb),
        .ser_rx    (ser_rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eol       (eol),
        .frame_err (frame_err),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Observe on the falling edge; inputs only move 1ns after a rising edge.
    always @(negedge clock) begin
        if (!resetb) begin
            hold = 1'b0;
        end else begin
            if (out_valid && out_ready) rcv.push_back(out_data);
            if (eol) eol_n++;
            if (frame_err) ferr_n++;
            if (overflow) ovf_n++;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (hold && out_valid && out_data !== hold_data) stab_err++;
            hold      = out_valid && !out_ready;
            hold_data = out_data;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_mon();
        rcv.delete();
        expq.delete();
        eol_n = 0; ferr_n = 0; ovf_n = 0; max_lvl = 0; stab_err = 0; exp_ovf = 0;
    endtask

    task automatic send_bit(input logic b);
        ser_rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    // Model for a consumer that is not reading: bytes beyond DEPTH are lost.
    task automatic model_push(input logic [7:0] d);
        if (expq.size() < DEPTH) expq.push_back(d);
        else exp_ovf++;
    endtask

    task automatic drain(input string name);
        int n;
        n = expq.size();
        out_ready = 1'b1;
        for (int c = 0; c < 100 && rcv.size() < n; c++) tick();
        tick(3);
        out_ready = 1'b0;
        chk_cnt++;
        if (rcv.size() !== n)
            $display("FAIL %s drain count: got %0d want %0d", name, rcv.size(), n);
        else pass_cnt++;
        for (int i = 0; i < n && i < rcv.size(); i++) begin
            chk_cnt++;
            if (rcv[i] !== expq[i])
                $display("FAIL %s byte %0d: got %02h want %02h", name, i, rcv[i], expq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        tick(3);
        chk_cnt++;
        if ({out_valid, out_data, eol, frame_err, overflow, level} !== '0)
            $display("FAIL reset outputs: valid=%b data=%02h eol=%b ferr=%b ovf=%b level=%0d want all 0",
                     out_valid, out_data, eol, frame_err, overflow, level);
        else pass_cnt++;
        resetb = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        clear_mon();
        out_ready = 1'b1;
        expq.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        tick(10);
        chk_cnt++;
        if (rcv.size() !== 1 || rcv[0] !== 8'h55)
            $display("FAIL single rx: got %0d bytes first %02h want 1 byte 55", rcv.size(),
                     rcv.size() > 0 ? rcv[0] : 8'hxx);
        else pass_cnt++;
        chk_cnt++;
        if (max_lvl !== 1) $display("FAIL single level peak: got %0d want 1", max_lvl);
        else pass_cnt++;
        chk_cnt++;
        if (eol_n + ferr_n + ovf_n !== 0)
            $display("FAIL single flags: eol=%0d ferr=%0d ovf=%0d want 0", eol_n, ferr_n, ovf_n);
        else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] s [3];
        s = '{8'h4F, 8'h4B, 8'h0A};
        clear_mon();
        foreach (s[i]) begin
            model_push(s[i]);
            send_frame(s[i], 1'b1);
        end
        tick(5);
        chk_cnt++;
        if (level !== 3'(expq.size())) $display("FAIL b2b level: got %0d want %0d", level, expq.size());
        else pass_cnt++;
        chk_cnt++;
        if (eol_n !== 1) $display("FAIL b2b eol pulses: got %0d want 1", eol_n);
        else pass_cnt++;
        tick(4);
        chk_cnt++;
        if (stab_err !== 0 || out_data !== 8'h4F)
            $display("FAIL b2b head hold: data=%02h stab_err=%0d want 4f/0", out_data, stab_err);
        else pass_cnt++;
        drain("b2b");
    endtask

    task automatic test_glitch();
        clear_mon();
        ser_rx = 1'b0;
        tick(3);
        ser_rx = 1'b1;
        tick(30);
        chk_cnt++;
        if (level !== 0 || out_valid !== 1'b0 || ferr_n !== 0)
            $display("FAIL glitch: level=%0d valid=%b ferr=%0d want 0/0/0", level, out_valid, ferr_n);
        else pass_cnt++;
        model_push(8'h3C);
        send_frame(8'h3C, 1'b1);
        tick(5);
        drain("glitch_after");
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_frame(8'hA5, 1'b0);
        ser_rx = 1'b0;
        tick(20);
        ser_rx = 1'b1;
        tick(2 * CPB);
        model_push(8'h31);
        send_frame(8'h31, 1'b1);
        tick(5);
        chk_cnt++;
        if (ferr_n !== 1) $display("FAIL frame_err pulses: got %0d want 1", ferr_n);
        else pass_cnt++;
        chk_cnt++;
        if (level !== 1) $display("FAIL frame_err level: got %0d want 1", level);
        else pass_cnt++;
        drain("frame_err");
    endtask

    task automatic test_overflow();
        clear_mon();
        for (int i = 1; i <= 5; i++) begin
            model_push(8'(i));
            send_frame(8'(i), 1'b1);
        end
        tick(5);
        chk_cnt++;
        if (level !== 3'(DEPTH)) $display("FAIL overflow level: got %0d want %0d", level, DEPTH);
        else pass_cnt++;
        chk_cnt++;
        if (ovf_n !== exp_ovf || eol_n !== 0)
            $display("FAIL overflow pulses: ovf=%0d eol=%0d want %0d/0", ovf_n, eol_n, exp_ovf);
        else pass_cnt++;
        drain("overflow");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        clear_mon();
        send_frame(8'h11, 1'b1);
        tick(5);
        chk_cnt++;
        if (level !== 1) $display("FAIL rstmid prefill level: got %0d want 1", level);
        else pass_cnt++;
        d = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        ser_rx = d[4];
        tick(CPB / 2);
        resetb = 1'b0;
        ser_rx = 1'b1;
        tick(3);
        chk_cnt++;
        if (level !== 0 || out_valid !== 1'b0 || out_data !== 8'h00)
            $display("FAIL rstmid flush: level=%0d valid=%b data=%02h want 0/0/00", level, out_valid, out_data);
        else pass_cnt++;
        resetb = 1'b1;
        tick(2);
        clear_mon();
        model_push(8'h7E);
        send_frame(8'h7E, 1'b1);
        tick(5);
        chk_cnt++;
        if (ferr_n !== 0 || level !== 1)
            $display("FAIL rstmid after: ferr=%0d level=%0d want 0/1", ferr_n, level);
        else pass_cnt++;
        drain("rstmid");
    endtask

    task automatic test_random();
        bit done = 0;
        int exp_eol = 0, exp_ferr = 0;
        clear_mon();
        fork
            begin
                for (int f = 0; f < 14; f++) begin
                    logic [7:0] d;
                    logic       stop;
                    int         gap;
                    d    = (f % 5 == 2) ? 8'h0A : 8'($urandom);
                    stop = ($urandom_range(0, 4) != 0);
                    gap  = $urandom_range(stop ? 0 : 1, 2);
                    if (stop) begin
                        expq.push_back(d);
                        if (d == 8'h0A) exp_eol++;
                    end else begin
                        exp_ferr++;
                    end
                    send_frame(d, stop);
                    ser_rx = 1'b1;
                    tick(gap * CPB);
                end
                tick(5);
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        drain("random");
        chk_cnt++;
        if (eol_n !== exp_eol || ferr_n !== exp_ferr || ovf_n !== 0)
            $display("FAIL random flags: eol=%0d ferr=%0d ovf=%0d want %0d/%0d/0",
                     eol_n, ferr_n, ovf_n, exp_eol, exp_ferr);
        else pass_cnt++;
        chk_cnt++;
        if (stab_err !== 0) $display("FAIL random head stability: %0d changes want 0", stab_err);
        else pass_cnt++;
    endtask

    initial begin
        tick();
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
